// File: rtl/dvi_init_seq.sv
// rtl/dvi_init_seq.sv - power-up reset and I2C register-table sequencer for the Chrontel DVI encoder
module dvi_init_seq #(
  parameter int         RST_CYCLES  = 100000,
  parameter int         WAIT_CYCLES = 100000,
  parameter logic [6:0] DEV_ADDR    = 7'h76,
  parameter int         MAX_RETRY   = 3
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       start,
  output logic       dvi_rst,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic [7:0] cmd_byte,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] retry_cnt
);

  localparam int CNT_MAX  = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int NUM_REGS = 5;

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    SEND,
    WAIT_RSP,
    DONE,
    ERROR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       reg_idx, reg_idx_n;
  logic [1:0]       byte_idx, byte_idx_n;
  logic [2:0]       attempt, attempt_n;
  logic [3:0]       retry_n;
  logic             load;

  function automatic logic [7:0] table_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    table_reg = 8'h49;
      3'd1:    table_reg = 8'h21;
      3'd2:    table_reg = 8'h33;
      3'd3:    table_reg = 8'h34;
      default: table_reg = 8'h36;
    endcase
  endfunction

  function automatic logic [7:0] table_data(input logic [2:0] idx);
    case (idx)
      3'd0:    table_data = 8'hC0;
      3'd1:    table_data = 8'h09;
      3'd2:    table_data = 8'h08;
      3'd3:    table_data = 8'h16;
      default: table_data = 8'h60;
    endcase
  endfunction

  function automatic logic [7:0] cmd_field(input logic [2:0] r, input logic [1:0] b);
    case (b)
      2'd0:    cmd_field = {DEV_ADDR, 1'b0};
      2'd1:    cmd_field = table_reg(r);
      default: cmd_field = table_data(r);
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    reg_idx_n  = reg_idx;
    byte_idx_n = byte_idx;
    attempt_n  = attempt;
    retry_n    = retry_cnt;
    load       = 1'b0;
    case (state)
      RST_HOLD: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          state_n = RST_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RST_WAIT: begin
        if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
          state_n    = SEND;
          cnt_n      = '0;
          reg_idx_n  = 3'd0;
          byte_idx_n = 2'd0;
          attempt_n  = 3'd0;
          load       = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SEND: begin
        if (cmd_ready) state_n = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          // A NACK on any byte restarts the whole register write from the address byte.
          if (rsp_nack) begin
            if (attempt < 3'(MAX_RETRY)) begin
              attempt_n  = attempt + 3'd1;
              byte_idx_n = 2'd0;
              if (retry_cnt != 4'hF) retry_n = retry_cnt + 4'd1;
              state_n    = SEND;
              load       = 1'b1;
            end else begin
              state_n = ERROR;
            end
          end else if (byte_idx == 2'd2) begin
            if (reg_idx == 3'(NUM_REGS - 1)) begin
              state_n = DONE;
            end else begin
              reg_idx_n  = reg_idx + 3'd1;
              byte_idx_n = 2'd0;
              attempt_n  = 3'd0;
              state_n    = SEND;
              load       = 1'b1;
            end
          end else begin
            byte_idx_n = byte_idx + 2'd1;
            state_n    = SEND;
            load       = 1'b1;
          end
        end
      end
      DONE, ERROR: begin
        if (start) begin
          state_n = RST_HOLD;
          cnt_n   = '0;
          retry_n = 4'd0;
        end
      end
      default: state_n = RST_HOLD;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst) begin
    if (!rst) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      reg_idx   <= 3'd0;
      byte_idx  <= 2'd0;
      attempt   <= 3'd0;
      retry_cnt <= 4'd0;
      cmd_byte  <= 8'h00;
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      reg_idx   <= reg_idx_n;
      byte_idx  <= byte_idx_n;
      attempt   <= attempt_n;
      retry_cnt <= retry_n;
      // Command fields are captured on entry to SEND so they stay stable while the master stalls.
      if (load) begin
        cmd_byte  <= cmd_field(reg_idx_n, byte_idx_n);
        cmd_start <= (byte_idx_n == 2'd0);
        cmd_stop  <= (byte_idx_n == 2'd2);
      end
    end
  end

  assign dvi_rst   = (state != RST_HOLD);
  assign cmd_valid = (state == SEND);
  assign busy      = (state != DONE) && (state != ERROR);
  assign done      = (state == DONE);
  assign error     = (state == ERROR);

endmodule

// File: tb/tb_dvi_init_seq.sv
// tb/tb_dvi_init_seq.sv - randomized bench for dvi_init_seq against a transaction-level model
module tb_dvi_init_seq;

  localparam int RST_CYCLES  = 4;
  localparam int WAIT_CYCLES = 4;
  localparam int MAX_RETRY   = 3;

  logic       clk_100mhz = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       dvi_rst;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic       cmd_start;
  logic       cmd_stop;
  logic [7:0] cmd_byte;
  logic       rsp_valid = 1'b0;
  logic       rsp_nack = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tbl_reg [5] = '{8'h49, 8'h21, 8'h33, 8'h34, 8'h36};
  logic [7:0] tbl_dat [5] = '{8'hC0, 8'h09, 8'h08, 8'h16, 8'h60};

  dvi_init_seq #(
    .RST_CYCLES (RST_CYCLES),
    .WAIT_CYCLES(WAIT_CYCLES),
    .DEV_ADDR   (7'h76),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .start     (start),
    .dvi_rst   (dvi_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_byte  (cmd_byte),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .retry_cnt (retry_cnt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int r, input int b);
    if (b == 0) return 8'hEC;
    if (b == 1) return tbl_reg[r];
    return tbl_dat[r];
  endfunction

  function automatic bit nack_decide(input int mode, input int r, input int b, input int a);
    case (mode)
      1:       return (r == 2) && (b == 1) && (a == 0);
      2:       return (b == 0);
      3:       return $urandom_range(0, 5) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_reset_vals();
    check("rv_dvi_rst",   32'(dvi_rst),   32'd0);
    check("rv_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rv_cmd_start", 32'(cmd_start), 32'd0);
    check("rv_cmd_stop",  32'(cmd_stop),  32'd0);
    check("rv_cmd_byte",  32'(cmd_byte),  32'd0);
    check("rv_busy",      32'(busy),      32'd1);
    check("rv_done",      32'(done),      32'd0);
    check("rv_error",     32'(error),     32'd0);
    check("rv_retry_cnt", 32'(retry_cnt), 32'd0);
  endtask

  task automatic restart();
    start = 1'b1;
    @(negedge clk_100mhz);
    start = 1'b0;
    check("rs_dvi_rst",   32'(dvi_rst),   32'd0);
    check("rs_done",      32'(done),      32'd0);
    check("rs_error",     32'(error),     32'd0);
    check("rs_busy",      32'(busy),      32'd1);
    check("rs_retry_cnt", 32'(retry_cnt), 32'd0);
  endtask

  // Called on the first negedge the encoder reset is asserted.
  task automatic measure_init();
    int n;
    n = 0;
    while (dvi_rst === 1'b0 && n < 50) begin
      n++;
      @(negedge clk_100mhz);
    end
    check("rst_low_cycles", 32'(n), 32'(RST_CYCLES));
    n = 0;
    while (dvi_rst === 1'b1 && cmd_valid === 1'b0 && n < 50) begin
      n++;
      @(negedge clk_100mhz);
    end
    check("wait_cycles", 32'(n), 32'(WAIT_CYCLES));
    check("first_byte",  32'(cmd_byte),  32'hEC);
    check("first_start", 32'(cmd_start), 32'd1);
    check("first_stop",  32'(cmd_stop),  32'd0);
  endtask

  task automatic run_seq(input int mode, input int hold_at, input int abort_reg);
    int m_reg, m_byte, m_att, m_retries, n_acc, cycles, dly, hold_left, out_reg;
    bit m_done, m_err, outstanding, cur_nack;
    logic [7:0] exp_b;
    m_reg = 0; m_byte = 0; m_att = 0; m_retries = 0; n_acc = 0; cycles = 0;
    dly = 0; out_reg = -1; m_done = 0; m_err = 0; outstanding = 0; cur_nack = 0;
    hold_left = (hold_at >= 0) ? 10 : 0;
    measure_init();
    while (busy === 1'b1 && cycles < 3000) begin
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      cmd_ready = 1'b0;
      start     = 1'b0;
      if (outstanding) begin
        if (out_reg == abort_reg) begin
          rst = 1'b0;
          #1;
          check_reset_vals();
          @(negedge clk_100mhz);
          rst = 1'b1;
          return;
        end
        if (dly == 0) begin
          rsp_valid   = 1'b1;
          rsp_nack    = cur_nack;
          outstanding = 1'b0;
        end else begin
          dly--;
          cmd_ready = 1'($urandom_range(0, 1));
        end
      end else if (hold_left > 0 && n_acc == hold_at && (cmd_valid === 1'b1 || hold_left < 10)) begin
        exp_b = exp_byte(m_reg, m_byte);
        check("hold_valid", 32'(cmd_valid), 32'd1);
        check("hold_byte",  32'(cmd_byte),  32'(exp_b));
        if (hold_left == 5) start = 1'b1;
        hold_left--;
      end else if (cmd_valid === 1'b1) begin
        exp_b = exp_byte(m_reg, m_byte);
        if ($urandom_range(0, 3) != 0) begin
          cmd_ready = 1'b1;
          check("cmd_byte",  32'(cmd_byte),  32'(exp_b));
          check("cmd_start", 32'(cmd_start), 32'(m_byte == 0));
          check("cmd_stop",  32'(cmd_stop),  32'(m_byte == 2));
          n_acc++;
          out_reg     = m_reg;
          outstanding = 1'b1;
          dly         = $urandom_range(0, 3);
          cur_nack    = nack_decide(mode, m_reg, m_byte, m_att);
          if (cur_nack) begin
            if (m_att < MAX_RETRY) begin
              m_att++;
              if (m_retries < 15) m_retries++;
              m_byte = 0;
            end else begin
              m_err = 1'b1;
            end
          end else if (m_byte == 2) begin
            m_byte = 0;
            m_att  = 0;
            if (m_reg == 4) m_done = 1'b1;
            else m_reg++;
          end else begin
            m_byte++;
          end
        end else begin
          rsp_valid = 1'($urandom_range(0, 1));
          rsp_nack  = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk_100mhz);
      cycles++;
    end
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    cmd_ready = 1'b0;
    start     = 1'b0;
    check("no_timeout",    32'(cycles < 3000), 32'd1);
    check("end_done",      32'(done),      32'(m_done));
    check("end_error",     32'(error),     32'(m_err));
    check("end_busy",      32'(busy),      32'd0);
    check("end_cmd_valid", 32'(cmd_valid), 32'd0);
    check("end_retry_cnt", 32'(retry_cnt), 32'(m_retries));
    if (mode == 0) check("acc_count_ack", 32'(n_acc), 32'd15);
    if (mode == 1) begin
      check("acc_count_nack1", 32'(n_acc), 32'd17);
      check("retry_nack1", 32'(retry_cnt), 32'd1);
    end
    if (mode == 2) begin
      check("acc_count_perm", 32'(n_acc), 32'd4);
      check("retry_perm", 32'(retry_cnt), 32'd3);
      check("error_perm", 32'(error), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    check_reset_vals();
    rst = 1'b1;
    run_seq(0, -1, -1);
    restart();
    run_seq(1, -1, -1);
    restart();
    run_seq(2, -1, -1);
    restart();
    run_seq(0, 4, -1);
    restart();
    run_seq(0, -1, 3);
    run_seq(0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      restart();
      run_seq(3, -1, -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
